// File: rtl/liteic_master_node_read_if.sv
// axi_lite_if: AXI-Lite read-channel bundle between a master and the interconnect.
//   ar_valid/ar_ready/ar_addr/ar_qos : read address channel
//   r_valid/r_ready/r_data/r_resp    : read data channel
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [3:0]            ar_qos;
    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;

    modport slave (
        input  ar_valid, ar_addr, ar_qos, r_ready,
        output ar_ready, r_valid, r_data, r_resp
    );

    modport master (
        output ar_valid, ar_addr, ar_qos, r_ready,
        input  ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/liteic_master_node_read.sv
// liteic_master_node_read: master-side read node, decodes AR to a slave slot,
// issues one crossbar request and routes the selected slot's R response back.
//   clk_i, rstn_i        : clock, asynchronous active-low reset
//   mst_axil             : AXI-Lite read channels from the master (slave side)
//   cbar_reqst_*         : request to crossbar (broadcast addr/qos, one-hot valid)
//   cbar_resp_*          : per-slot response words/valids, one-hot response ready
//   busy_o               : a read is outstanding
module liteic_master_node_read #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int REGION_LSB = 28,
    parameter int SEL_WIDTH  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    axi_lite_if.slave             mst_axil,
    output logic [ADDR_WIDTH-1:0] cbar_reqst_data_o,
    output logic [3:0]            cbar_reqst_arqos_o,
    output logic [NUM_SLAVES-1:0] cbar_reqst_val_o,
    input  logic [NUM_SLAVES-1:0] cbar_reqst_rdy_i,
    input  logic [DATA_WIDTH+1:0] cbar_resp_data_i [NUM_SLAVES],
    input  logic [NUM_SLAVES-1:0] cbar_resp_val_i,
    output logic [NUM_SLAVES-1:0] cbar_resp_rdy_o,
    output logic                  busy_o
);
    localparam int IDX_WIDTH = ADDR_WIDTH - REGION_LSB;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DECERR} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            qos_q, qos_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    // Holds ar_ready low until the first clock edge after reset release.
    logic                  live_q;
    logic [IDX_WIDTH-1:0]  idx;
    logic [NUM_SLAVES-1:0] sel_oh;

    assign idx                = mst_axil.ar_addr[ADDR_WIDTH-1:REGION_LSB];
    assign sel_oh             = NUM_SLAVES'(1) << sel_q;
    assign cbar_reqst_data_o  = addr_q;
    assign cbar_reqst_arqos_o = qos_q;
    assign busy_o             = state_q != IDLE;

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        qos_d             = qos_q;
        sel_d             = sel_q;
        mst_axil.ar_ready = 1'b0;
        mst_axil.r_valid  = 1'b0;
        mst_axil.r_data   = '0;
        mst_axil.r_resp   = '0;
        cbar_reqst_val_o  = '0;
        cbar_resp_rdy_o   = '0;
        case (state_q)
            IDLE: begin
                mst_axil.ar_ready = live_q;
                if (mst_axil.ar_valid && live_q) begin
                    addr_d = mst_axil.ar_addr;
                    qos_d  = mst_axil.ar_qos;
                    // Full upper field is compared so aliased high indices decode as unmapped.
                    if (32'(idx) < NUM_SLAVES) begin
                        sel_d   = idx[SEL_WIDTH-1:0];
                        state_d = REQ;
                    end else begin
                        state_d = DECERR;
                    end
                end
            end
            REQ: begin
                cbar_reqst_val_o = sel_oh;
                if (cbar_reqst_rdy_i[sel_q]) state_d = RESP;
            end
            RESP: begin
                mst_axil.r_valid                   = cbar_resp_val_i[sel_q];
                {mst_axil.r_data, mst_axil.r_resp} = cbar_resp_data_i[sel_q];
                cbar_resp_rdy_o                    = mst_axil.r_ready ? sel_oh : '0;
                if (cbar_resp_val_i[sel_q] && mst_axil.r_ready) state_d = IDLE;
            end
            DECERR: begin
                mst_axil.r_valid = 1'b1;
                mst_axil.r_resp  = 2'b11;
                if (mst_axil.r_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            qos_q   <= '0;
            sel_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            qos_q   <= qos_d;
            sel_q   <= sel_d;
            live_q  <= 1'b1;
        end
    end
endmodule
